mc_datapath: RTL and testbench



---
 rtl/mc_datapath.sv | 240 ++++++++++++++++++++++++
 tb/tb_mc_datapath.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_datapath.sv
// Multi-cycle RV32-style datapath: FETCH/DECODE/EXEC/MEM/WB over one req/ack memory port.
// Optional MC_PERF_CNT_EN adds free-running cycle and retired-instruction counters.
module mc_datapath #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int RF_ADDRESS = 5,
    parameter int ALU_CC_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                RegWrite,
    input  logic                MemtoReg,
    input  logic                ALUsrc,
    input  logic                MemWrite,
    input  logic                MemRead,
    input  logic                Con_beq,
    input  logic                Con_bnq,
    input  logic                Con_bgt,
    input  logic                Con_blt,
    input  logic                Jal,
    input  logic                Con_Jalr,
    input  logic                AUIPC,
    input  logic                LUI,
    input  logic [ALU_CC_W-1:0] ALU_CC,
    output logic [6:0]          opcode,
    output logic [6:0]          Funct7,
    output logic [2:0]          Funct3,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [DATA_W-1:0]   ALU_Result,
`ifdef MC_PERF_CNT_EN
    output logic [31:0]         cycle_cnt,
    output logic [31:0]         instret_cnt,
`endif
    output logic [2:0]          state,
    output logic                instr_retired
);

    localparam int SH_W = $clog2(DATA_W);
    localparam logic [ALU_CC_W-1:0] CC_AND = ALU_CC_W'(0);
    localparam logic [ALU_CC_W-1:0] CC_OR  = ALU_CC_W'(1);
    localparam logic [ALU_CC_W-1:0] CC_ADD = ALU_CC_W'(2);
    localparam logic [ALU_CC_W-1:0] CC_SUB = ALU_CC_W'(6);
    localparam logic [ALU_CC_W-1:0] CC_SLT = ALU_CC_W'(7);
    localparam logic [ALU_CC_W-1:0] CC_XOR = ALU_CC_W'(8);
    localparam logic [ALU_CC_W-1:0] CC_SLL = ALU_CC_W'(9);
    localparam logic [ALU_CC_W-1:0] CC_SRL = ALU_CC_W'(10);
    localparam logic [ALU_CC_W-1:0] CC_SRA = ALU_CC_W'(11);
    localparam logic [ADDR_W-1:0]   ALIGN  = ~ADDR_W'(3);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t                  st, st_n;
    logic [ADDR_W-1:0]       pc, pc_i;
    logic [31:0]             ir, imm32;
    logic [DATA_W-1:0]       a, b, imm, alu_q, mdr;
    logic [DATA_W-1:0]       regs [1 << RF_ADDRESS];
    logic [RF_ADDRESS-1:0]   rs1, rs2, rd;
    logic [DATA_W-1:0]       imm_ext, opb, alu_y, wb_val;
    logic [SH_W-1:0]         shamt;
    logic                    zero, gt, lt, is_br, taken, is_mem, slt;
    logic [ADDR_W-1:0]       seq_pc, br_pc, jr_pc;

    assign opcode    = ir[6:0];
    assign Funct3    = ir[14:12];
    assign Funct7    = ir[31:25];
    assign rd        = ir[7 +: RF_ADDRESS];
    assign rs1       = ir[15 +: RF_ADDRESS];
    assign rs2       = ir[20 +: RF_ADDRESS];
    assign state     = st;
    assign mem_wdata = b;
    assign mem_addr  = (st == S_MEM) ? alu_q[ADDR_W-1:0] : pc;

    always_comb begin
        case (ir[6:0])
            7'b0100011: imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            7'b1100011: imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            7'b1101111: imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            7'b0110111,
            7'b0010111: imm32 = {ir[31:12], 12'b0};
            default:    imm32 = {{20{ir[31]}}, ir[31:20]};
        endcase
        imm_ext = {{(DATA_W-31){imm32[31]}}, imm32[30:0]};
    end

    always_comb begin
        opb   = ALUsrc ? imm : b;
        shamt = opb[SH_W-1:0];
        slt   = $signed(a) < $signed(opb);
        case (ALU_CC)
            CC_AND:  alu_y = a & opb;
            CC_OR:   alu_y = a | opb;
            CC_ADD:  alu_y = a + opb;
            CC_SUB:  alu_y = a - opb;
            CC_SLT:  alu_y = DATA_W'(slt);
            CC_XOR:  alu_y = a ^ opb;
            CC_SLL:  alu_y = a << shamt;
            CC_SRL:  alu_y = a >> shamt;
            CC_SRA:  alu_y = DATA_W'($signed(a) >>> shamt);
            default: alu_y = '0;
        endcase
    end

    assign zero   = (alu_y == '0);
    assign gt     = $signed(a) > $signed(b);
    assign lt     = $signed(a) < $signed(b);
    assign is_br  = Con_beq | Con_bnq | Con_bgt | Con_blt;
    assign taken  = (Con_beq & zero) | (Con_bnq & ~zero)
                  | (Con_bgt & gt) | (Con_blt & lt);
    assign is_mem = MemRead | MemWrite;
    assign seq_pc = pc + ADDR_W'(4);
    assign br_pc  = (pc + imm[ADDR_W-1:0]) & ALIGN;
    assign jr_pc  = (a[ADDR_W-1:0] + imm[ADDR_W-1:0]) & ALIGN;

    always_comb begin
        if (LUI)                 wb_val = imm;
        else if (AUIPC)          wb_val = DATA_W'(pc_i) + imm;
        else if (Jal | Con_Jalr) wb_val = DATA_W'(pc_i + ADDR_W'(4));
        else if (MemtoReg)       wb_val = mdr;
        else                     wb_val = alu_q;
    end

    always_ff @(posedge clk) begin
        if (reset) st <= S_FETCH;
        else       st <= st_n;
    end

    always_comb begin
        st_n          = st;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        instr_retired = 1'b0;
        case (st)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) st_n = S_DECODE;
            end
            S_DECODE: st_n = S_EXEC;
            S_EXEC: begin
                if (is_br) begin
                    instr_retired = 1'b1;
                    st_n          = S_FETCH;
                end else if (is_mem) begin
                    st_n = S_MEM;
                end else begin
                    st_n = S_WB;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = MemWrite;
                if (mem_ack) begin
                    instr_retired = MemWrite;
                    st_n          = MemWrite ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                instr_retired = 1'b1;
                st_n          = S_FETCH;
            end
            default: st_n = S_FETCH;
        endcase
        // nothing leaves the block while reset is held, so a late ack cannot land
        if (reset) begin
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            instr_retired = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc         <= '0;
            pc_i       <= '0;
            ir         <= '0;
            a          <= '0;
            b          <= '0;
            imm        <= '0;
            alu_q      <= '0;
            mdr        <= '0;
            ALU_Result <= '0;
            for (int i = 0; i < (1 << RF_ADDRESS); i++) regs[i] <= '0;
        end else begin
            case (st)
                S_FETCH: begin
                    if (mem_ack) begin
                        ir   <= mem_rdata[31:0];
                        pc_i <= pc;
                    end
                end
                S_DECODE: begin
                    a   <= regs[rs1];
                    b   <= regs[rs2];
                    imm <= imm_ext;
                end
                S_EXEC: begin
                    alu_q <= alu_y;
                    if (is_br)         pc <= taken ? br_pc : seq_pc;
                    else if (Jal)      pc <= br_pc;
                    else if (Con_Jalr) pc <= jr_pc;
                    else if (!is_mem)  pc <= seq_pc;
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mdr <= mem_rdata;
                        pc  <= seq_pc;
                    end
                end
                S_WB: begin
                    ALU_Result <= wb_val;
                    if (RegWrite && rd != '0) regs[rd] <= wb_val;
                end
                default: ;
            endcase
        end
    end

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (instr_retired) instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_datapath.sv
// Directed program bench for mc_datapath with a wait-state memory model,
// a small control decoder and a scoreboard of per-instruction expectations.
module tb_mc_datapath;

    localparam int AW = 12;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          RegWrite, MemtoReg, ALUsrc, MemWrite, MemRead;
    logic          Con_beq, Con_bnq, Con_bgt, Con_blt;
    logic          Jal, Con_Jalr, AUIPC, LUI;
    logic [3:0]    ALU_CC;
    logic [6:0]    opcode, Funct7;
    logic [2:0]    Funct3;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata, ALU_Result;
    logic [2:0]    state;
    logic          instr_retired;
`ifdef MC_PERF_CNT_EN
    logic [31:0]   cycle_cnt, instret_cnt;
`endif

    mc_datapath dut (
        .clk(clk), .reset(reset),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ALUsrc(ALUsrc),
        .MemWrite(MemWrite), .MemRead(MemRead),
        .Con_beq(Con_beq), .Con_bnq(Con_bnq), .Con_bgt(Con_bgt),
        .Con_blt(Con_blt), .Jal(Jal), .Con_Jalr(Con_Jalr),
        .AUIPC(AUIPC), .LUI(LUI), .ALU_CC(ALU_CC),
        .opcode(opcode), .Funct7(Funct7), .Funct3(Funct3),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ALU_Result(ALU_Result),
`ifdef MC_PERF_CNT_EN
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
`endif
        .state(state), .instr_retired(instr_retired)
    );

    function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic f7b5, input logic rtype);
        case (f3)
            3'b000:  return (rtype && f7b5) ? 4'b0110 : 4'b0010;
            3'b111:  return 4'b0000;
            3'b110:  return 4'b0001;
            3'b100:  return 4'b1000;
            3'b010:  return 4'b0111;
            3'b001:  return 4'b1001;
            3'b101:  return f7b5 ? 4'b1011 : 4'b1010;
            default: return 4'b1111;
        endcase
    endfunction

    // external control decoder model
    always_comb begin
        RegWrite = 0; MemtoReg = 0; ALUsrc = 0; MemWrite = 0; MemRead = 0;
        Con_beq = 0; Con_bnq = 0; Con_bgt = 0; Con_blt = 0;
        Jal = 0; Con_Jalr = 0; AUIPC = 0; LUI = 0; ALU_CC = 4'b0010;
        case (opcode)
            7'b0010011: begin RegWrite = 1; ALUsrc = 1; ALU_CC = alu_code(Funct3, Funct7[5], 1'b0); end
            7'b0110011: begin RegWrite = 1; ALU_CC = alu_code(Funct3, Funct7[5], 1'b1); end
            7'b0000011: begin RegWrite = 1; MemtoReg = 1; ALUsrc = 1; MemRead = 1; end
            7'b0100011: begin ALUsrc = 1; MemWrite = 1; end
            7'b1100011: begin
                ALU_CC  = 4'b0110;
                Con_beq = (Funct3 == 3'b000);
                Con_bnq = (Funct3 == 3'b001);
                Con_blt = (Funct3 == 3'b100);
                Con_bgt = (Funct3 == 3'b101);
            end
            7'b1101111: begin RegWrite = 1; Jal = 1; end
            7'b1100111: begin RegWrite = 1; Con_Jalr = 1; ALUsrc = 1; end
            7'b0110111: begin RegWrite = 1; LUI = 1; end
            7'b0010111: begin RegWrite = 1; AUIPC = 1; end
            default: ;
        endcase
    end

    logic [31:0]   mem [0:1023];
    int            delay_n = 0;
    logic [AW-1:0] delay_addr = '0;
    bit            hold = 0;
    bit            force_ack = 0;
    int            st_cnt = 0;
    logic [AW-1:0] st_addr = '0;
    logic [31:0]   st_data = '0;

    // memory responder: acts on the falling edge, optional one-shot wait states
    initial begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (hold) begin
                mem_ack = force_ack;
            end else if (mem_req) begin
                if (delay_n > 0 && mem_addr == delay_addr && !mem_we) begin
                    mem_ack = 1'b0;
                    delay_n--;
                end else begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem[mem_addr[AW-1:2]] = mem_wdata;
                        st_cnt++;
                        st_addr = mem_addr;
                        st_data = mem_wdata;
                    end
                    mem_rdata = mem[mem_addr[AW-1:2]];
                end
            end else begin
                mem_ack = 1'b0;
            end
        end
    end

    typedef struct {
        logic [AW-1:0] npc;
        logic [31:0]   res;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    logic [2:0]    st_log [1:8];
    logic          rq_log [1:8];
    logic [AW-1:0] ad_log [1:8];
    logic [6:0]    op_log [1:8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [AW-1:0] npc, input logic [31:0] res, input int lat);
        exp_t e;
        e.npc = npc; e.res = res; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic rec(input int n);
        if (n <= 8) begin
            st_log[n] = state; rq_log[n] = mem_req;
            ad_log[n] = mem_addr; op_log[n] = opcode;
        end
    endtask

    // entered #1 after the falling edge of the instruction's first FETCH cycle
    task automatic step(input string tag);
        exp_t e;
        int n;
        e = sb.pop_front();
        n = 1;
        rec(n);
        while (!instr_retired && n < 40) begin
            @(negedge clk); #1;
            n++;
            rec(n);
        end
        chk({tag, ".latency"}, 32'(n), 32'(e.lat));
        @(negedge clk); #1;
        chk({tag, ".state"}, 32'(state), 32'd0);
        chk({tag, ".next_pc"}, 32'(mem_addr), 32'(e.npc));
        chk({tag, ".alu_result"}, ALU_Result, e.res);
    endtask

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
        logic [11:0] v;
        v = imm[11:0];
        return {v, 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [11:0] v;
        v = imm[11:0];
        return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [12:0] v;
        v = imm[12:0];
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [20:0] v;
        v = imm[20:0];
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_u(input int imm, input int rd, input logic [6:0] op);
        logic [19:0] v;
        v = imm[19:0];
        return {v, 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
    endfunction

    task automatic put(input int addr, input logic [31:0] w);
        mem[addr >> 2] = w;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        put('h000, enc_i(5, 0, 0, 1, 7'b0010011));
        put('h004, enc_s('h40, 1, 0));
        put('h008, enc_i('h40, 0, 2, 2, 7'b0000011));
        put('h00C, enc_i(9, 0, 0, 0, 7'b0010011));
        put('h010, enc_b(-8, 2, 1, 0));
        put('h014, enc_i('h101, 0, 0, 1, 7'b0010011));
        put('h018, enc_r(0, 0, 0, 0, 6));
        put('h01C, enc_u('h12345, 7, 7'b0110111));
        put('h020, enc_i(3, 1, 0, 5, 7'b1100111));
        put('h104, enc_u(1, 8, 7'b0010111));
        put('h108, enc_j(8, 9));
        put('h110, enc_r('h20, 1, 0, 0, 11));
        put('h114, enc_i('h404, 11, 5, 12, 7'b0010011));
        put('h118, enc_r(0, 8, 5, 0, 10));
        put('h11C, enc_s('h44, 5, 0));
        delay_addr = 'h004;
        delay_n = 3;

        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); #1;
        chk("rst.mem_req", 32'(mem_req), 0);
        chk("rst.state", 32'(state), 0);
        chk("rst.alu_result", ALU_Result, 0);
        chk("rst.retired", 32'(instr_retired), 0);
        chk("rst.ir_fields", {15'd0, Funct7, Funct3, opcode}, 0);

        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        chk("first.mem_req", 32'(mem_req), 1);
        chk("first.mem_addr", 32'(mem_addr), 0);

        push('h004, 5, 4);
        step("addi_x1_5");

        push('h008, 5, 7);
        step("sw_wait3");
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("fetchwait.state%0d", i), 32'(st_log[i]), 0);
            chk($sformatf("fetchwait.req%0d", i), 32'(rq_log[i]), 1);
            chk($sformatf("fetchwait.addr%0d", i), 32'(ad_log[i]), 'h004);
        end
        chk("fetchwait.ir_before_ack", 32'(op_log[4]), 'h13);
        chk("fetchwait.ir_after_ack", 32'(op_log[5]), 'h23);
        chk("sw.count", 32'(st_cnt), 1);
        chk("sw.addr", 32'(st_addr), 'h40);
        chk("sw.wdata", st_data, 5);

        push('h00C, 5, 5);
        step("lw_x2");
        push('h010, 9, 4);
        step("addi_x0_9");
        push('h008, 9, 3);
        step("beq_taken");
        mem['h40 >> 2] = 32'd4;
        push('h00C, 4, 5);
        step("lw_x2_again");
        push('h010, 9, 4);
        step("addi_x0_again");
        push('h014, 9, 3);
        step("beq_untaken");
        push('h018, 'h101, 4);
        step("addi_x1_101");
        push('h01C, 0, 4);
        step("add_x0_x0");
        push('h020, 'h12345000, 4);
        step("lui");
        push('h104, 'h24, 4);
        step("jalr");
        push('h108, 'h1104, 4);
        step("auipc");
        push('h110, 'h10C, 4);
        step("jal");
        push('h114, 'hFFFFFEFF, 4);
        step("sub");
        push('h118, 'hFFFFFFEF, 4);
        step("srai");
        push('h11C, 'h1128, 4);
        step("add_link");

        hold = 1;
        force_ack = 0;
        repeat (3) begin @(negedge clk); #1; end
        chk("stmem.state", 32'(state), 3);
        chk("stmem.req", 32'(mem_req), 1);
        chk("stmem.we", 32'(mem_we), 1);
        chk("stmem.addr", 32'(mem_addr), 'h44);
        chk("stmem.wdata", mem_wdata, 'h24);
        reset = 1'b1;
        @(negedge clk); #1;
        chk("midrst.req", 32'(mem_req), 0);
        chk("midrst.state", 32'(state), 0);
        chk("midrst.pc", 32'(mem_addr), 0);
        chk("midrst.alu_result", ALU_Result, 0);
        force_ack = 1;
        @(negedge clk); #1;
        chk("lateack.state", 32'(state), 0);
        chk("lateack.req", 32'(mem_req), 0);
        force_ack = 0;
        @(negedge clk); #1;
        chk("lateack.no_store", mem['h44 >> 2], 0);
        chk("lateack.store_count", 32'(st_cnt), 1);
        hold = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        push('h004, 5, 4);
        step("addi_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
